// File: rtl/pulse_cmd_pkg.sv
// Shared constants, state encoding and byte helpers
// for the pulse-parameter command link.
package pulse_cmd_pkg;

   localparam logic [7:0] CMD_DELAY    = 8'd0;
   localparam logic [7:0] CMD_PERIOD   = 8'd1;
   localparam logic [7:0] CMD_PULSE1   = 8'd2;
   localparam logic [7:0] CMD_PULSE2   = 8'd3;
   localparam logic [7:0] CMD_BLOCK    = 8'd4;
   localparam logic [7:0] CMD_CPMG     = 8'd5;
   localparam logic [7:0] CMD_ATT      = 8'd6;
   localparam logic [7:0] CMD_NUTATION = 8'd7;

   localparam int CMD_NBYTES = 5;

   typedef enum logic [2:0] {
      S_IDLE,
      S_TX_LOAD,
      S_TX_WAIT_HI,
      S_TX_WAIT_LO,
      S_WAIT_RSP,
      S_REPORT
   } state_t;

   // Echo checksum covers only the value bytes, never the control code.
   function automatic logic [7:0] data_csum(input logic [31:0] d);
      return d[7:0] + d[15:8] + d[23:16] + d[31:24];
   endfunction

   function automatic logic [7:0] pick_byte(
      input logic [31:0] d,
      input logic [7:0]  c,
      input logic [2:0]  i
   );
      case (i)
         3'd0:    return d[7:0];
         3'd1:    return d[15:8];
         3'd2:    return d[23:16];
         3'd3:    return d[31:24];
         default: return c;
      endcase
   endfunction

endpackage

// File: rtl/cmd_timeout_ctr.sv
// Down-counter for the echo wait window:
// load, decrement to zero, zero flag.
module cmd_timeout_ctr #(
   parameter int MAX = 2_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic dec,
   output logic zero
);

   localparam int W = $clog2(MAX + 1);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (load)
         cnt <= W'(MAX);
      else if (dec && (cnt != '0))
         cnt <= cnt - 1'b1;
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/pulse_cmd_sender.sv
// Sends one 5-byte command to the uart and
// waits for the checksum echo from the controller.
module pulse_cmd_sender
   import pulse_cmd_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 2_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [7:0]  cmd_ctrl,
   input  logic [31:0] cmd_data,
   output logic        transmit,
   output logic [7:0]  tx_byte,
   input  logic        is_transmitting,
   input  logic        received,
   input  logic [7:0]  rx_byte,
   input  logic        recv_error,
   output logic        busy,
   output logic        done,
   output logic        ack_ok,
   output logic        ack_err,
   output logic        timeout,
   output logic [7:0]  rsp_byte
);

   state_t      state, state_n;
   logic [2:0]  idx_q, idx_n;
   logic [31:0] data_q;
   logic [7:0]  ctrl_q;
   logic [7:0]  exp_q;
   logic        accept;
   logic        tmo_load, tmo_dec, tmo_zero;

   logic        transmit_d, busy_d, done_d;
   logic        ok_d, err_d, to_d;
   logic [7:0]  tx_byte_d, rsp_d;

   assign cmd_ready = (state == S_IDLE);
   assign accept    = cmd_valid && cmd_ready;
   assign tmo_load  = (state == S_TX_WAIT_LO) && (state_n == S_WAIT_RSP);
   assign tmo_dec   = (state == S_WAIT_RSP);

   cmd_timeout_ctr #(
      .MAX (TIMEOUT_CYCLES)
   ) u_tmo (
      .clk  (clk),
      .rst  (rst),
      .load (tmo_load),
      .dec  (tmo_dec),
      .zero (tmo_zero)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         idx_q    <= '0;
         data_q   <= '0;
         ctrl_q   <= '0;
         exp_q    <= '0;
         transmit <= 1'b0;
         tx_byte  <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         ack_ok   <= 1'b0;
         ack_err  <= 1'b0;
         timeout  <= 1'b0;
         rsp_byte <= '0;
      end else begin
         state    <= state_n;
         idx_q    <= idx_n;
         transmit <= transmit_d;
         tx_byte  <= tx_byte_d;
         busy     <= busy_d;
         done     <= done_d;
         ack_ok   <= ok_d;
         ack_err  <= err_d;
         timeout  <= to_d;
         rsp_byte <= rsp_d;
         if (accept) begin
            data_q <= cmd_data;
            ctrl_q <= cmd_ctrl;
            exp_q  <= data_csum(cmd_data);
         end
      end
   end

   always_comb begin
      state_n = state;
      idx_n   = idx_q;
      unique case (state)
         S_IDLE: begin
            if (cmd_valid) begin
               state_n = S_TX_LOAD;
               idx_n   = '0;
            end
         end
         S_TX_LOAD: begin
            if (transmit)
               state_n = S_TX_WAIT_HI;
         end
         S_TX_WAIT_HI: begin
            if (is_transmitting)
               state_n = S_TX_WAIT_LO;
         end
         S_TX_WAIT_LO: begin
            if (!is_transmitting) begin
               idx_n = idx_q + 3'd1;
               if (idx_q == 3'(CMD_NBYTES - 1))
                  state_n = S_WAIT_RSP;
               else
                  state_n = S_TX_LOAD;
            end
         end
         S_WAIT_RSP: begin
            if (received || recv_error || tmo_zero)
               state_n = S_REPORT;
         end
         S_REPORT: state_n = S_IDLE;
         default:  state_n = S_IDLE;
      endcase
   end

   // Registered outputs are computed one cycle ahead from state_n.
   always_comb begin
      transmit_d = (state_n == S_TX_LOAD) && !is_transmitting;
      tx_byte_d  = tx_byte;
      if (transmit_d) begin
         if (state == S_IDLE)
            tx_byte_d = cmd_data[7:0];
         else
            tx_byte_d = pick_byte(data_q, ctrl_q, idx_n);
      end
      busy_d = (state_n != S_IDLE);
      done_d = (state == S_WAIT_RSP) && (state_n == S_REPORT);
      ok_d   = done_d && received && !recv_error
               && (rx_byte == exp_q);
      err_d  = done_d && (recv_error
               || (received && (rx_byte != exp_q)));
      to_d   = done_d && !received && !recv_error;
      rsp_d  = rsp_byte;
      if ((state == S_WAIT_RSP) && received)
         rsp_d = rx_byte;
   end

endmodule
